// File: rtl/dsp_be_prbs_pkg.sv
// Shared types and polynomial constants for the BE PRBS generator/checker.
// Tap pairs follow b[n] = b[n-K1] ^ b[n-K2] with the newest bit at state[L-1].
package dsp_be_prbs_pkg;

  typedef enum logic [2:0] {
    DISABLE = 3'b000,
    SEED    = 3'b110,
    RUN     = 3'b010
  } pgen_cfg_e;

  typedef enum logic [1:0] {
    POLY_7      = 2'd0,
    POLY_15     = 2'd1,
    POLY_31     = 2'd2,
    POLY_31_ALT = 2'd3
  } poly_sel_e;

  localparam int P7_L   = 7;
  localparam int P7_K1  = 6;
  localparam int P7_K2  = 7;
  localparam int P15_L  = 15;
  localparam int P15_K1 = 14;
  localparam int P15_K2 = 15;
  localparam int P31_L  = 31;
  localparam int P31_K1 = 28;
  localparam int P31_K2 = 31;

  function automatic logic [30:0] poly_mask(input poly_sel_e p);
    logic [30:0] m;
    unique case (p)
      POLY_7:  m = 31'h0000_007F;
      POLY_15: m = 31'h0000_7FFF;
      default: m = 31'h7FFF_FFFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dsp_be_prbs_step.sv
// Combinational OUT_BITS-step LFSR unroll; word[0] is the earliest bit.
// Shared by the transmitter and the checker-side model.
module dsp_be_prbs_step
  import dsp_be_prbs_pkg::*;
#(
  parameter int OUT_BITS = 64
) (
  input  logic [30:0]         state,
  input  logic [1:0]          poly,
  output logic [30:0]         next_state,
  output logic [OUT_BITS-1:0] word
);

  poly_sel_e   p;
  logic [30:0] s;
  logic        nb;

  assign p = poly_sel_e'(poly);

  always_comb begin
    s    = state & poly_mask(p);
    nb   = 1'b0;
    word = '0;
    for (int i = 0; i < OUT_BITS; i++) begin
      unique case (p)
        POLY_7: begin
          nb = s[P7_L-P7_K1] ^ s[P7_L-P7_K2];
          s  = {24'd0, nb, s[6:1]};
        end
        POLY_15: begin
          nb = s[P15_L-P15_K1] ^ s[P15_L-P15_K2];
          s  = {16'd0, nb, s[14:1]};
        end
        POLY_31, POLY_31_ALT: begin
          nb = s[P31_L-P31_K1] ^ s[P31_L-P31_K2];
          s  = {nb, s[30:1]};
        end
      endcase
      word[i] = nb;
    end
    next_state = s;
  end

endmodule

// File: rtl/dsp_be_prbs_tx.sv
// Parallel PRBS7/15/31 transmitter with periodic single-bit error injection.
// Optional output inversion enabled by defining DSP_BE_PRBS_TX_OUT_INV_EN.
module dsp_be_prbs_tx
  import dsp_be_prbs_pkg::*;
#(
  parameter int OUT_BITS     = 64,
  parameter int INJ_PERIOD_W = 16,
  parameter int INJ_CNT_W    = 32
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [2:0]                  i_cfg,
  input  logic [1:0]                  i_poly_sel,
  input  logic [30:0]                 i_seed,
  input  logic                        i_inj_en,
  input  logic [INJ_PERIOD_W-1:0]     i_inj_period,
  input  logic [$clog2(OUT_BITS)-1:0] i_inj_bit,
`ifdef DSP_BE_PRBS_TX_OUT_INV_EN
  input  logic                        i_cfg_out_inv,
`endif
  output logic [OUT_BITS-1:0]         o_data,
  output logic                        o_valid,
  output logic                        o_seed_good,
  output logic [INJ_CNT_W-1:0]        o_inj_count
);

  logic [30:0]             lfsr;
  logic [30:0]             lfsr_nxt;
  logic [30:0]             mask;
  logic [30:0]             seed_m;
  logic [30:0]             seed_ld;
  logic [30:0]             step_next;
  logic [OUT_BITS-1:0]     step_word;
  logic [OUT_BITS-1:0]     inj_mask;
  logic [OUT_BITS-1:0]     tx_word;
  logic [INJ_PERIOD_W-1:0] phase;
  logic                    is_run;
  logic                    is_seed;
  logic                    inj_on;
  logic                    inj_hit;

  assign mask    = poly_mask(poly_sel_e'(i_poly_sel));
  assign seed_m  = i_seed & mask;
  assign seed_ld = (seed_m == '0) ? mask : seed_m;
  assign is_run  = (i_cfg == RUN);
  assign is_seed = (i_cfg == SEED);

  dsp_be_prbs_step #(
    .OUT_BITS(OUT_BITS)
  ) u_step (
    .state(lfsr),
    .poly(i_poly_sel),
    .next_state(step_next),
    .word(step_word)
  );

  assign inj_on  = i_inj_en && (i_inj_period != '0);
  assign inj_hit = inj_on &&
    (phase == i_inj_period - INJ_PERIOD_W'(1));
  assign inj_mask = inj_hit ?
    (OUT_BITS'(1) << i_inj_bit) : '0;

`ifdef DSP_BE_PRBS_TX_OUT_INV_EN
  assign tx_word = (step_word ^ inj_mask) ^
    {OUT_BITS{i_cfg_out_inv}};
`else
  assign tx_word = step_word ^ inj_mask;
`endif

  // Injection touches only the output word, never the LFSR
  always_comb begin
    lfsr_nxt = lfsr;
    if (is_seed)
      lfsr_nxt = seed_ld;
    else if (is_run)
      lfsr_nxt = step_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lfsr        <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_seed_good <= 1'b0;
      o_inj_count <= '0;
      phase       <= '0;
    end else begin
      lfsr        <= lfsr_nxt;
      o_seed_good <= |(lfsr_nxt & mask);
      o_data      <= is_run ? tx_word : '0;
      o_valid     <= is_run;
      if (is_seed)
        phase <= '0;
      else if (is_run && inj_on)
        phase <= inj_hit ? '0 : phase + INJ_PERIOD_W'(1);
      if (is_run && inj_hit && (o_inj_count != '1))
        o_inj_count <= o_inj_count + INJ_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dsp_be_prbs_tx.sv
// Scoreboard bench for dsp_be_prbs_tx against a bit-serial history model.
// Counter width is reduced so saturation is reachable in a short run.
module tb_dsp_be_prbs_tx;

  localparam int CW = 8;
  localparam logic [2:0] C_DIS  = 3'b000;
  localparam logic [2:0] C_SEED = 3'b110;
  localparam logic [2:0] C_RUN  = 3'b010;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [2:0]    i_cfg;
  logic [1:0]    i_poly_sel;
  logic [30:0]   i_seed;
  logic          i_inj_en;
  logic [15:0]   i_inj_period;
  logic [5:0]    i_inj_bit;
  logic [63:0]   o_data;
  logic          o_valid;
  logic          o_seed_good;
  logic [CW-1:0] o_inj_count;

  always #5 clk = ~clk;

  dsp_be_prbs_tx #(
    .OUT_BITS(64),
    .INJ_PERIOD_W(16),
    .INJ_CNT_W(CW)
  ) dut (
    .i_clk(clk),
    .i_rst(i_rst),
    .i_cfg(i_cfg),
    .i_poly_sel(i_poly_sel),
    .i_seed(i_seed),
    .i_inj_en(i_inj_en),
    .i_inj_period(i_inj_period),
    .i_inj_bit(i_inj_bit),
`ifdef DSP_BE_PRBS_TX_OUT_INV_EN
    .i_cfg_out_inv(1'b0),
`endif
    .o_data(o_data),
    .o_valid(o_valid),
    .o_seed_good(o_seed_good),
    .o_inj_count(o_inj_count)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;
  string       tag;

  bit          mq[$];
  int          mk1;
  int          mk2;
  int          ml = 7;
  logic [15:0] exp_phase;
  int          exp_cnt;
  logic [63:0] sb[$];
  logic [63:0] hist[$];

  task automatic model_seed(input logic [1:0] poly,
                            input logic [30:0] seed);
    logic [30:0] s;
    case (poly)
      2'd0:    begin ml = 7;  mk1 = 6;  mk2 = 7;  end
      2'd1:    begin ml = 15; mk1 = 14; mk2 = 15; end
      default: begin ml = 31; mk1 = 28; mk2 = 31; end
    endcase
    s = seed & ((31'd1 << ml) - 31'd1);
    if (ml == 31) s = seed;
    if (s == '0) s = '1;
    mq.delete();
    for (int j = 0; j < ml; j++) mq.push_back(s[j]);
  endtask

  task automatic model_reset();
    mq.delete();
    for (int j = 0; j < ml; j++) mq.push_back(1'b0);
    exp_phase = '0;
    exp_cnt   = 0;
    sb.delete();
  endtask

  function automatic logic [63:0] model_word();
    logic [63:0] w;
    bit nb;
    for (int i = 0; i < 64; i++) begin
      nb = mq[mq.size()-mk1] ^ mq[mq.size()-mk2];
      w[i] = nb;
      mq.push_back(nb);
      void'(mq.pop_front());
    end
    return w;
  endfunction

  task automatic cyc(input logic [2:0] cfg);
    logic [63:0] w;
    logic [63:0] e;
    logic        run;
    run = !i_rst && (cfg == C_RUN);
    i_cfg = cfg;
    if (i_rst) begin
      model_reset();
    end else if (cfg == C_RUN) begin
      w = model_word();
      if (i_inj_en && i_inj_period != 0) begin
        if (exp_phase == i_inj_period - 16'd1) begin
          w[i_inj_bit] = ~w[i_inj_bit];
          exp_phase = '0;
          if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        end else begin
          exp_phase = exp_phase + 16'd1;
        end
      end
      sb.push_back(w);
    end else if (cfg == C_SEED) begin
      model_seed(i_poly_sel, i_seed);
      exp_phase = '0;
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (run) begin
      e = sb.pop_front();
      if (o_data !== e || o_valid !== 1'b1)
        $display("FAIL %s word: data=%h valid=%b want data=%h valid=1",
                 tag, o_data, o_valid, e);
      else n_pass++;
    end else begin
      if (o_data !== '0 || o_valid !== 1'b0)
        $display("FAIL %s idle: data=%h valid=%b want 0/0",
                 tag, o_data, o_valid);
      else n_pass++;
    end
    hist.push_back(o_data);
  endtask

  task automatic chk_cnt(input int want);
    n_chk++;
    if (o_inj_count !== CW'(want) || o_inj_count !== CW'(exp_cnt))
      $display("FAIL %s inj_count: got %0d want %0d (model %0d)",
               tag, o_inj_count, want, exp_cnt);
    else n_pass++;
  endtask

  task automatic chk_sg(input logic want);
    n_chk++;
    if (o_seed_good !== want)
      $display("FAIL %s seed_good: got %b want %b", tag, o_seed_good, want);
    else n_pass++;
  endtask

  task automatic test_reset();
    tag = "reset";
    i_rst = 1'b1;
    cyc(C_RUN);
    cyc(C_RUN);
    chk_sg(1'b0);
    chk_cnt(0);
    i_rst = 1'b0;
  endtask

  task automatic test_prbs7();
    tag = "prbs7";
    i_poly_sel = 2'd0;
    i_seed = 31'h7F;
    cyc(C_SEED);
    n_chk++;
    if (o_valid !== 1'b0)
      $display("FAIL prbs7 valid_before_run: got %b want 0", o_valid);
    else n_pass++;
    hist.delete();
    cyc(C_RUN);
    n_chk++;
    if (o_data[6:0] !== 7'h40)
      $display("FAIL prbs7 first_word: got %h want 40", o_data[6:0]);
    else n_pass++;
    for (int k = 1; k < 254; k++) cyc(C_RUN);
    for (int k = 0; k < 127; k++) begin
      n_chk++;
      if (hist[k+127] !== hist[k])
        $display("FAIL prbs7 period127 k=%0d: got %h want %h",
                 k, hist[k+127], hist[k]);
      else n_pass++;
    end
    chk_sg(1'b1);
  endtask

  task automatic test_prbs15_31();
    for (int p = 1; p <= 2; p++) begin
      tag = (p == 1) ? "prbs15" : "prbs31";
      i_poly_sel = 2'(p);
      i_seed = 31'd1;
      cyc(C_SEED);
      for (int k = 0; k < 1000; k++) cyc(C_RUN);
      chk_sg(1'b1);
    end
    tag = "seed0";
    i_poly_sel = 2'd1;
    i_seed = 31'd0;
    cyc(C_SEED);
    for (int k = 0; k < 50; k++) cyc(C_RUN);
    chk_sg(1'b1);
  endtask

  task automatic test_inj_period();
    tag = "inj100";
    i_poly_sel = 2'd2;
    i_seed = 31'd1;
    i_inj_en = 1'b1;
    i_inj_period = 16'd100;
    i_inj_bit = 6'd5;
    cyc(C_SEED);
    for (int k = 0; k < 10000; k++) cyc(C_RUN);
    chk_cnt(100);
  endtask

  task automatic test_inj_bounds();
    tag = "inj_p0";
    i_inj_period = 16'd0;
    for (int k = 0; k < 200; k++) cyc(C_RUN);
    chk_cnt(100);
    tag = "inj_p1";
    i_inj_period = 16'd1;
    i_inj_bit = 6'd63;
    for (int k = 0; k < 155; k++) cyc(C_RUN);
    chk_cnt(255);
    tag = "inj_sat";
    for (int k = 0; k < 20; k++) cyc(C_RUN);
    chk_cnt(255);
    i_inj_en = 1'b0;
  endtask

  task automatic test_rst_mid_run();
    tag = "rst_mid";
    i_poly_sel = 2'd0;
    i_seed = 31'h55;
    cyc(C_SEED);
    for (int k = 0; k < 10; k++) cyc(C_RUN);
    i_rst = 1'b1;
    cyc(C_RUN);
    chk_sg(1'b0);
    chk_cnt(0);
    i_rst = 1'b0;
    tag = "run_noseed";
    for (int k = 0; k < 10; k++) cyc(C_RUN);
    chk_sg(1'b0);
    tag = "resume";
    i_seed = 31'h3;
    cyc(C_SEED);
    for (int k = 0; k < 40; k++) cyc(C_RUN);
    for (int k = 0; k < 5; k++) cyc(C_DIS);
    for (int k = 0; k < 40; k++) cyc(C_RUN);
  endtask

  initial begin
    i_rst = 1'b1;
    i_cfg = C_DIS;
    i_poly_sel = 2'd0;
    i_seed = '0;
    i_inj_en = 1'b0;
    i_inj_period = '0;
    i_inj_bit = '0;
    model_seed(2'd0, 31'h7F);
    model_reset();
    test_reset();
    test_prbs7();
    test_prbs15_31();
    test_inj_period();
    test_inj_bounds();
    test_rst_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
